// File: rtl/match_ctrl_pkg.sv
// rtl/match_ctrl_pkg.sv - shared state, winner and serve encodings for the pong match controller
package match_ctrl_pkg;

  typedef enum logic {
    ST_FREEZE = 1'b0,
    ST_PLAY   = 1'b1
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/match_ctrl_freeze_timer.sv
// rtl/match_ctrl_freeze_timer.sv - freeze down-counter with load, skip-to-1, zero and one flags
module match_ctrl_freeze_timer #(
  parameter int FREEZE_W  = 14,
  parameter int RESET_VAL = 16383
) (
  input  logic                game_clk,
  input  logic                reset,
  input  logic                load,
  input  logic [FREEZE_W-1:0] load_val,
  input  logic                skip,
  input  logic                dec,
  output logic                is_zero,
  output logic                is_one
);

  logic [FREEZE_W-1:0] count;

  always_ff @(posedge game_clk) begin
    if (reset) begin
      count <= FREEZE_W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (skip) begin
      count <= FREEZE_W'(1);
    end else if (dec && (count != '0)) begin
      count <= count - FREEZE_W'(1);
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == FREEZE_W'(1));

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - pong match controller: freeze countdowns, scoring, win/deuce and speed ramp
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int WIN_BY2      = 0,
  parameter int FREEZE_W     = 14,
  parameter int POINT_FREEZE = 2000,
  parameter int MATCH_FREEZE = 16383,
  parameter int SPEED_W      = 5,
  parameter int BASE_SPEED   = 11,
  parameter int MAX_SPEED    = 15,
  parameter int RAMP_HITS    = 4,
  parameter int SPEED_STEP   = 1
) (
  input  logic               game_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               out_left,
  input  logic               out_right,
  input  logic               hit,
  output logic [SPEED_W-1:0] speed,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner
);

  localparam int HIT_W = (RAMP_HITS > 1) ? $clog2(RAMP_HITS) : 1;
  localparam logic [HIT_W-1:0]          HIT_LAST   = HIT_W'((RAMP_HITS > 0) ? RAMP_HITS - 1 : 0);
  localparam logic [SCORE_W:0]          WIN_X      = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [FREEZE_W-1:0]       POINT_LOAD = FREEZE_W'(POINT_FREEZE);
  localparam logic [FREEZE_W-1:0]       MATCH_LOAD = FREEZE_W'(MATCH_FREEZE);
  localparam logic [SPEED_W-1:0]        BASE_V     = SPEED_W'(BASE_SPEED);
  localparam logic signed [SPEED_W:0]   MAX_X      = (SPEED_W+1)'(MAX_SPEED);
  localparam logic signed [SPEED_W:0]   STEP_X     = (SPEED_W+1)'(SPEED_STEP);
  localparam bit                        RAMP_ON    = (RAMP_HITS != 0);
  localparam bit                        DEUCE_ON   = (WIN_BY2 != 0);

  state_t             state, state_next;
  logic [SPEED_W-1:0] speed_next;
  logic               ball_reset_next;
  logic               serve_next;
  logic [SCORE_W-1:0] p1_next, p2_next;
  logic [1:0]         winner_next;
  logic [HIT_W-1:0]   hit_cnt, hit_cnt_next;

  logic                t_load, t_skip, t_dec, t_zero, t_one;
  logic [FREEZE_W-1:0] t_load_val;

  logic [SCORE_W-1:0]       s_cur, o_cur, s_val, o_val;
  logic [SCORE_W:0]         s_new;
  logic [SCORE_W+1:0]       o_plus2;
  logic                     point, win, deuce;
  logic signed [SPEED_W:0]  ramp_sum;
  logic [SPEED_W-1:0]       ramp_speed;

  match_ctrl_freeze_timer #(
    .FREEZE_W  (FREEZE_W),
    .RESET_VAL (MATCH_FREEZE)
  ) u_freeze (
    .game_clk (game_clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .skip     (t_skip),
    .dec      (t_dec),
    .is_zero  (t_zero),
    .is_one   (t_one)
  );

  // Scorer/other views: out_left wins a simultaneous out, so it selects p1 as scorer.
  assign point   = out_left | out_right;
  assign s_cur   = out_left ? score_p1 : score_p2;
  assign o_cur   = out_left ? score_p2 : score_p1;
  assign s_new   = {1'b0, s_cur} + (SCORE_W+1)'(1);
  assign o_plus2 = {2'b00, o_cur} + (SCORE_W+2)'(2);
  assign win     = (s_new >= WIN_X) && (!DEUCE_ON || ({1'b0, s_new} >= o_plus2));
  assign deuce   = DEUCE_ON && !win && (s_new >= WIN_X) && ({1'b0, o_cur} >= WIN_X);

  // Deuce pulls both players back one point, keeping the lead intact.
  assign s_val = deuce ? s_cur : s_new[SCORE_W-1:0];
  assign o_val = deuce ? (o_cur - SCORE_W'(1)) : o_cur;

  assign ramp_sum   = $signed({speed[SPEED_W-1], speed}) + STEP_X;
  assign ramp_speed = (ramp_sum > MAX_X) ? MAX_X[SPEED_W-1:0] : ramp_sum[SPEED_W-1:0];

  always_comb begin
    state_next      = state;
    speed_next      = speed;
    ball_reset_next = 1'b0;
    serve_next      = serve_dir;
    p1_next         = score_p1;
    p2_next         = score_p2;
    winner_next     = winner;
    hit_cnt_next    = hit_cnt;
    t_load          = 1'b0;
    t_load_val      = POINT_LOAD;
    t_skip          = 1'b0;
    t_dec           = 1'b0;

    case (state)
      ST_FREEZE: begin
        ball_reset_next = t_one;
        if (t_zero) begin
          state_next   = ST_PLAY;
          speed_next   = BASE_V;
          hit_cnt_next = '0;
        end else begin
          if (start) t_skip = 1'b1;
          else       t_dec  = 1'b1;
          if (t_one && (winner != WINNER_NONE)) begin
            p1_next     = '0;
            p2_next     = '0;
            winner_next = WINNER_NONE;
          end
        end
      end

      ST_PLAY: begin
        if (point) begin
          state_next = ST_FREEZE;
          speed_next = '0;
          serve_next = out_left ? SERVE_LEFT : SERVE_RIGHT;
          t_load     = 1'b1;
          if (out_left) begin
            p1_next = s_val;
            p2_next = o_val;
          end else begin
            p2_next = s_val;
            p1_next = o_val;
          end
          if (win) begin
            winner_next = out_left ? WINNER_P1 : WINNER_P2;
            t_load_val  = MATCH_LOAD;
          end
        end else if (hit && RAMP_ON) begin
          if (hit_cnt == HIT_LAST) begin
            hit_cnt_next = '0;
            speed_next   = ramp_speed;
          end else begin
            hit_cnt_next = hit_cnt + HIT_W'(1);
          end
        end
      end

      default: state_next = ST_FREEZE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state      <= ST_FREEZE;
      speed      <= '0;
      ball_reset <= 1'b1;
      serve_dir  <= SERVE_LEFT;
      score_p1   <= '0;
      score_p2   <= '0;
      winner     <= WINNER_NONE;
      hit_cnt    <= '0;
    end else begin
      state      <= state_next;
      speed      <= speed_next;
      ball_reset <= ball_reset_next;
      serve_dir  <= serve_next;
      score_p1   <= p1_next;
      score_p2   <= p2_next;
      winner     <= winner_next;
      hit_cnt    <= hit_cnt_next;
    end
  end

endmodule
